// File: rtl/pipeline_pkg.sv
// Shared decode-pipeline types: scheduler FSM states and register-file constants.
// No logic; imported by the scheduler and its scoreboard.
// No flow control of its own.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    STALL = 2'd2,
    ISSUE = 2'd3
  } sched_state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         REG_COUNT = 32;

endpackage

// File: rtl/decode_scheduler_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus an in-flight write counter.
// Latency: set/clear take effect on the next rising edge; full is combinational from the counter.
// Backpressure: none internally; the scheduler holds issue while full is high.
module decode_scheduler_scoreboard
  import pipeline_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_vld,
  input  logic [4:0]           set_idx,
  input  logic                 clr_vld,
  input  logic [4:0]           clr_idx,
  output logic [REG_COUNT-1:0] busy,
  output logic [CNT_W-1:0]     inflight,
  output logic                 full
);

  logic set_en;
  logic clr_en;

  // x0 is never tracked; a writeback for a register nobody is waiting on is dropped.
  assign set_en = set_vld && (set_idx != REG_ZERO);
  assign clr_en = clr_vld && (clr_idx != REG_ZERO) && busy[clr_idx];
  assign full   = (inflight == CNT_W'(MAX_INFLIGHT));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      inflight <= '0;
    end else begin
      // Set is written last so a same-register set+clear leaves the bit high.
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
      case ({set_en, clr_en})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: rtl/decode_scheduler.sv
// Decode-stage sequencer: fetch accept, regfile read, RAW/WAW hazard hold, issue. HAZARD_BYPASS_EN enables wb-to-decode bypass.
// Latency: fetch handshake at N, regfile read at N+1, issue_valid at N+2 when hazard-free.
// Backpressure: fetch_ready only in IDLE; issue_valid held until issue_ready; flush abandons the instruction.
module decode_scheduler
  import pipeline_pkg::*;
#(
  parameter int  MAX_INFLIGHT = 4,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             rs1_read,
  input  logic             rs2_read,
  input  logic [4:0]       rd,
  input  logic             rd_write,
  input  logic             instr_valid,
  input  logic             flush,
  output logic             rs_read,
  output logic             decode_req,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             illegal,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] inflight,
  output logic [31:0]      stall_cycles
);

  sched_state_t         state, state_nxt;
  logic                 full;
  logic                 hazard;
  logic                 sb_set;
  logic [REG_COUNT-1:0] busy_eff;

`ifdef HAZARD_BYPASS_EN
  logic [REG_COUNT-1:0] wb_mask;

  // A register retiring this cycle is already safe to read from the regfile.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
  end
  assign busy_eff = busy & ~wb_mask;
`else
  assign busy_eff = busy;
`endif

  assign hazard = (rs1_read && (rs1 != REG_ZERO) && busy_eff[rs1])
                | (rs2_read && (rs2 != REG_ZERO) && busy_eff[rs2])
                | (rd_write && (rd  != REG_ZERO) && busy_eff[rd])
                | (rd_write && (rd  != REG_ZERO) && full);

  // A flushed issue handshake must not leave a stale busy bit behind.
  assign sb_set = (state == ISSUE) && issue_ready && !flush && rd_write;

  decode_scheduler_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (CNT_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_vld (sb_set),
    .set_idx (rd),
    .clr_vld (wb_valid),
    .clr_idx (wb_rd),
    .busy    (busy),
    .inflight(inflight),
    .full    (full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_valid) state_nxt = READ;
      READ: begin
        if (!instr_valid) state_nxt = IDLE;
        else if (hazard)  state_nxt = STALL;
        else              state_nxt = ISSUE;
      end
      STALL:   if (!hazard) state_nxt = ISSUE;
      ISSUE:   if (issue_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      decode_req   <= 1'b0;
      illegal      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      decode_req   <= (state_nxt == ISSUE) && (state != ISSUE);
      illegal      <= (state == READ) && !instr_valid && !flush;
      if ((state == STALL) && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign fetch_ready = (state == IDLE);
  assign rs_read     = (state == READ) || (state == STALL);
  assign issue_valid = (state == ISSUE);

endmodule

// File: tb/tb_decode_scheduler.sv
// Directed bench for decode_scheduler (default MAX_INFLIGHT=4); honours HAZARD_BYPASS_EN when defined.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_decode_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid, fetch_ready;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        rs1_read, rs2_read, rd_write, instr_valid, flush;
  logic        rs_read, decode_req, issue_valid, issue_ready, wb_valid, illegal;
  logic [31:0] busy, stall_cycles;
  logic [2:0]  inflight;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

`ifdef HAZARD_BYPASS_EN
  localparam int T2_STALL = 3;
`else
  localparam int T2_STALL = 4;
`endif

  always #5 clk = ~clk;

  decode_scheduler dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .rs1(rs1), .rs2(rs2), .rs1_read(rs1_read), .rs2_read(rs2_read),
    .rd(rd), .rd_write(rd_write), .instr_valid(instr_valid), .flush(flush),
    .rs_read(rs_read), .decode_req(decode_req), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .illegal(illegal),
    .busy(busy), .inflight(inflight), .stall_cycles(stall_cycles)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full fetch->issue with issue_ready high; returns cycles from fetch handshake to issue_valid.
  task automatic do_instr(input logic [4:0] r1, input logic r1r, input logic [4:0] r2,
                          input logic r2r, input logic [4:0] d, input logic dw, output int l);
    rs1 = r1; rs1_read = r1r; rs2 = r2; rs2_read = r2r; rd = d; rd_write = dw;
    instr_valid = 1'b1; issue_ready = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    l = 1;
    while (issue_valid !== 1'b1 && l < 60) begin
      step();
      l++;
    end
    if (issue_valid !== 1'b1) check_val("do_instr_timeout", {31'd0, issue_valid}, 32'd1);
    step();
    issue_ready = 1'b0; rs1_read = 1'b0; rs2_read = 1'b0; rd_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] drain [4];
    drain = '{5'd2, 5'd3, 5'd4, 5'd6};
    reset = 1'b1; fetch_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; wb_rd = '0;
    rs1_read = 1'b0; rs2_read = 1'b0; rd_write = 1'b0; instr_valid = 1'b1;
    flush = 1'b0; issue_ready = 1'b0; wb_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // 1: reset state, then a single x5 write issued at N+2
    check_val("rst_fetch_ready", fetch_ready, 1);
    check_val("rst_rs_read", rs_read, 0);
    check_val("rst_issue_valid", issue_valid, 0);
    check_val("rst_decode_req", decode_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_inflight", inflight, 0);
    check_val("rst_stall", stall_cycles, 0);
    check_val("rst_illegal", illegal, 0);
    rd = 5'd5; rd_write = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    check_val("t1_read_rs_read", rs_read, 1);
    check_val("t1_read_no_issue", issue_valid, 0);
    step();
    check_val("t1_issue_at_n2", issue_valid, 1);
    check_val("t1_decode_req", decode_req, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0; rd_write = 1'b0;
    check_val("t1_busy", busy, 32'h20);
    check_val("t1_inflight", inflight, 1);
    check_val("t1_back_idle", fetch_ready, 1);

    // 2: RAW on x5, writeback during the third stall cycle
    rs1 = 5'd5; rs1_read = 1'b1; issue_ready = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    step();
    check_val("t2_stall_rs_read", rs_read, 1);
    check_val("t2_stall_hold", issue_valid, 0);
    step(); step();
    wb_valid = 1'b1; wb_rd = 5'd5;
    step();
    wb_valid = 1'b0;
`ifndef HAZARD_BYPASS_EN
    check_val("t2_still_stall", issue_valid, 0);
    check_val("t2_busy_cleared", busy, 0);
    step();
`endif
    check_val("t2_issue_after_wb", issue_valid, 1);
    check_val("t2_stall_cycles", stall_cycles, T2_STALL);
    check_val("t2_inflight", inflight, 0);
    step();
    issue_ready = 1'b0; rs1_read = 1'b0;
    check_val("t2_idle", fetch_ready, 1);

    // 3: fill to MAX_INFLIGHT, fifth write waits for any writeback
    for (int r = 1; r <= 4; r++) do_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, lat);
    check_val("t3_busy_full", busy, 32'h1E);
    check_val("t3_inflight_full", inflight, 4);
    rd = 5'd6; rd_write = 1'b1; issue_ready = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    step();
    check_val("t3_full_stall", issue_valid, 0);
    check_val("t3_inflight_cap", inflight, 4);
    wb_valid = 1'b1; wb_rd = 5'd1;
    step();
    wb_valid = 1'b0;
    check_val("t3_still_stall", issue_valid, 0);
    check_val("t3_inflight_dec", inflight, 3);
    step();
    check_val("t3_issue", issue_valid, 1);
    step();
    issue_ready = 1'b0; rd_write = 1'b0;
    check_val("t3_busy", busy, 32'h5C);
    check_val("t3_inflight", inflight, 4);
    do_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, lat);
    check_val("t3_x0_latency", lat, 2);
    check_val("t3_x0_no_stall", stall_cycles, T2_STALL + 2);

    // 4: x0 never tracked, stray writebacks ignored, illegal drop
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_rd = drain[i];
      step();
    end
    wb_valid = 1'b0;
    check_val("t4_drained_busy", busy, 0);
    check_val("t4_drained_inflight", inflight, 0);
    do_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, lat);
    wb_valid = 1'b1; wb_rd = 5'd0;
    step();
    wb_rd = 5'd9;
    step();
    wb_valid = 1'b0;
    check_val("t4_rd0_busy", busy, 0);
    check_val("t4_rd0_inflight", inflight, 0);
    instr_valid = 1'b0; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    check_val("t4_illegal_read", rs_read, 1);
    check_val("t4_illegal_not_yet", illegal, 0);
    step();
    check_val("t4_illegal_pulse", illegal, 1);
    check_val("t4_illegal_idle", fetch_ready, 1);
    step();
    instr_valid = 1'b1;
    check_val("t4_illegal_one_cycle", illegal, 0);

    // 5: issue_ready low for three cycles, then flush concurrent with handshake
    rd = 5'd10; rd_write = 1'b1; issue_ready = 1'b0; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("t5_issue_held", issue_valid, 1);
      if (decode_req === 1'b1) pulses++;
    end
    check_val("t5_decode_req_pulses", pulses, 1);
    flush = 1'b1; issue_ready = 1'b1;
    step();
    flush = 1'b0; issue_ready = 1'b0; rd_write = 1'b0;
    check_val("t5_flush_issue_drop", issue_valid, 0);
    check_val("t5_flush_idle", fetch_ready, 1);
    check_val("t5_flush_no_set", busy, 0);

    // 6: set/clear collisions, then reset in the middle of a stall
    do_instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, lat);
    check_val("t6_x7_busy", busy, 32'h80);
    // rd_write raised only in ISSUE to line the set up with the old x7 writeback
    rd = 5'd7; rd_write = 1'b0; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    step();
    rd_write = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7; issue_ready = 1'b1;
    step();
    wb_valid = 1'b0; issue_ready = 1'b0; rd_write = 1'b0;
    check_val("t6_same_reg_busy", busy, 32'h80);
    check_val("t6_same_reg_inflight", inflight, 1);
    rd = 5'd11; rd_write = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    step();
    wb_valid = 1'b1; wb_rd = 5'd7; issue_ready = 1'b1;
    step();
    wb_valid = 1'b0; issue_ready = 1'b0; rd_write = 1'b0;
    check_val("t6_diff_reg_busy", busy, 32'h800);
    check_val("t6_diff_reg_inflight", inflight, 1);
    rs1 = 5'd11; rs1_read = 1'b1; fetch_valid = 1'b1;
    step();
    fetch_valid = 1'b0;
    step();
    step();
    check_val("t6_in_stall", rs_read, 1);
    reset = 1'b1;
    step();
    check_val("t6_rst_fetch_ready", fetch_ready, 1);
    check_val("t6_rst_rs_read", rs_read, 0);
    check_val("t6_rst_issue_valid", issue_valid, 0);
    check_val("t6_rst_decode_req", decode_req, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_inflight", inflight, 0);
    check_val("t6_rst_stall", stall_cycles, 0);
    check_val("t6_rst_illegal", illegal, 0);
    reset = 1'b0; rs1_read = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
